sra_32_iter: RTL

SRA_32_ITER -- requirements
Module: sra_32_iter

---
 rtl/sra_32_iter.sv | 102 ++++++++++
 1 files changed

// File: rtl/sra_32_iter.sv
// rtl/sra_32_iter.sv - iterative 32-bit right shifter, five log-steps, fixed 5-cycle latency
// Optional sign fill is compiled in with SRA_32_ITER_ARITH_EN.
module sra_32_iter (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] data_operandA,
    input  logic [4:0]  shamt,
    input  logic        arith,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] work_q, work_d;
    logic [4:0]  shamt_q, shamt_d;
    logic        fill_q, fill_d;
    logic        rdy_en_q, rdy_en_d;

    logic [4:0]  step_amt;
    logic [31:0] shifted;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 3'd0;
            work_q   <= 32'd0;
            shamt_q  <= 5'd0;
            fill_q   <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            shamt_q  <= shamt_d;
            fill_q   <= fill_d;
            rdy_en_q <= rdy_en_d;
        end
    end

    // Stage k moves by 16>>k, so the five stages together cover any 0..31 amount.
    always_comb begin
        step_amt = 5'd16 >> cnt_q;
        shifted  = (work_q >> step_amt) | ({32{fill_q}} & ~(32'hFFFF_FFFF >> step_amt));
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        shamt_d  = shamt_q;
        fill_d   = fill_q;
        rdy_en_d = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    work_d  = data_operandA;
                    shamt_d = shamt;
`ifdef SRA_32_ITER_ARITH_EN
                    fill_d  = arith & data_operandA[31];
`else
                    fill_d  = arith & 1'b0;
`endif
                    cnt_d   = 3'd0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (shamt_q[3'd4 - cnt_q]) begin
                    work_d = shifted;
                end
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd4) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // rdy_en_q keeps in_ready low until the first edge after reset release.
    assign in_ready  = rdy_en_q && (state_q == S_IDLE);
    assign out       = work_q;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);

endmodule
